// File: rtl/lisa_qqspi_arb.sv
// rtl/lisa_qqspi_arb.sv - arbitrates one shared quad/single SPI memory controller between NUM_REQ requesters
// The grant is held for the whole burst and released only once the controller has dropped ready.
module lisa_qqspi_arb #(
   parameter int NUM_REQ      = 2,
   parameter int CHIP_SELECTS = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             prio_fixed,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*24-1:0]            req_addr,
   input  logic [NUM_REQ*16-1:0]            req_wdata,
   input  logic [NUM_REQ*2-1:0]             req_wstrb,
   input  logic [NUM_REQ*4-1:0]             req_len,
   input  logic [NUM_REQ*CHIP_SELECTS-1:0]  req_ce,
   input  logic [NUM_REQ-1:0]               req_ready_ack,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [NUM_REQ-1:0]               req_done,
   output logic [15:0]                      req_rdata,
   output logic [NUM_REQ-1:0]               grant,
   output logic [23:0]                      spi_addr,
   output logic [15:0]                      spi_wdata,
   output logic [1:0]                       spi_wstrb,
   output logic [3:0]                       spi_xfer_len,
   output logic [CHIP_SELECTS-1:0]          spi_ce_ctrl,
   output logic                             spi_valid,
   output logic                             spi_ready_ack,
   input  logic [15:0]                      spi_rdata,
   input  logic                             spi_ready,
   input  logic                             spi_xfer_done
);

   localparam int RRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_XFER  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [23:0]             addr_a  [NUM_REQ];
   logic [15:0]             wdata_a [NUM_REQ];
   logic [1:0]              wstrb_a [NUM_REQ];
   logic [3:0]              len_a   [NUM_REQ];
   logic [CHIP_SELECTS-1:0] ce_a    [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_a[i]  = req_addr[i*24 +: 24];
      assign wdata_a[i] = req_wdata[i*16 +: 16];
      assign wstrb_a[i] = req_wstrb[i*2 +: 2];
      assign len_a[i]   = req_len[i*4 +: 4];
      assign ce_a[i]    = req_ce[i*CHIP_SELECTS +: CHIP_SELECTS];
   end

   logic [1:0]              state_q, state_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [RRW-1:0]          gidx_q, gidx_d;
   logic [RRW-1:0]          rr_q, rr_d;
   logic [23:0]             addr_q, addr_d;
   logic [1:0]              wstrb_q, wstrb_d;
   logic [3:0]              len_q, len_d;
   logic [CHIP_SELECTS-1:0] ce_q, ce_d;
   logic                    valid_q, valid_d;

   logic                    win_found;
   logic [RRW-1:0]          win_idx;
   logic [NUM_REQ-1:0]      win_oh;
   logic [RRW-1:0]          cand_idx;
   int                      cand;
   logic [RRW-1:0]          rr_next;
   logic                    in_xfer;

   // Scan candidates starting at 0 (fixed) or at the round-robin pointer, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      win_oh    = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = prio_fixed ? k : k + int'(rr_q);
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = RRW'(cand);
         if (!win_found && req_valid[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         win_oh[k] = win_found && (win_idx == RRW'(k));
      end
   end

   assign rr_next = (gidx_q == RRW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      rr_d    = rr_q;
      addr_d  = addr_q;
      wstrb_d = wstrb_q;
      len_d   = len_q;
      ce_d    = ce_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               grant_d = win_oh;
               gidx_d  = win_idx;
               addr_d  = addr_a[win_idx];
               wstrb_d = wstrb_a[win_idx];
               len_d   = len_a[win_idx];
               ce_d    = ce_a[win_idx];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            valid_d = 1'b1;
            state_d = ST_XFER;
         end
         ST_XFER: begin
            if (spi_xfer_done) begin
               valid_d = 1'b0;
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // A lingering ready must never be mistaken for a beat of the next burst.
            if (!spi_ready) begin
               grant_d = '0;
               if (!prio_fixed) rr_d = rr_next;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         rr_q    <= '0;
         addr_q  <= '0;
         wstrb_q <= '0;
         len_q   <= '0;
         ce_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         rr_q    <= rr_d;
         addr_q  <= addr_d;
         wstrb_q <= wstrb_d;
         len_q   <= len_d;
         ce_q    <= ce_d;
         valid_q <= valid_d;
      end
   end

   assign in_xfer       = (state_q == ST_XFER);
   assign req_ready     = (in_xfer && spi_ready) ? grant_q : '0;
   assign req_done      = (in_xfer && spi_xfer_done) ? grant_q : '0;
   assign req_rdata     = spi_rdata;
   assign grant         = grant_q;
   assign spi_addr      = addr_q;
   assign spi_wstrb     = wstrb_q;
   assign spi_xfer_len  = len_q;
   assign spi_ce_ctrl   = ce_q;
   assign spi_valid     = valid_q;
   assign spi_ready_ack = in_xfer && req_ready_ack[gidx_q];
   // Write data bypasses the latch so each beat of a burst can carry fresh data.
   assign spi_wdata     = (grant_q != '0) ? wdata_a[gidx_q] : '0;

endmodule

// File: tb/tb_lisa_qqspi_arb.sv
// tb/tb_lisa_qqspi_arb.sv - scoreboard bench for lisa_qqspi_arb with a behavioural arbiter and controller model
module tb_lisa_qqspi_arb;

   localparam int N  = 2;
   localparam int CS = 2;

   typedef struct packed {
      logic [1:0]    who;
      logic [23:0]   addr;
      logic [1:0]    wstrb;
      logic [3:0]    len;
      logic [CS-1:0] ce;
   } txn_t;

   logic            clk;
   logic            rst;
   logic            prio_fixed;
   logic [N-1:0]    req_valid;
   logic [N*24-1:0] req_addr;
   logic [N*16-1:0] req_wdata;
   logic [N*2-1:0]  req_wstrb;
   logic [N*4-1:0]  req_len;
   logic [N*CS-1:0] req_ce;
   logic [N-1:0]    req_ready_ack;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_done;
   logic [15:0]     req_rdata;
   logic [N-1:0]    grant;
   logic [23:0]     spi_addr;
   logic [15:0]     spi_wdata;
   logic [1:0]      spi_wstrb;
   logic [3:0]      spi_xfer_len;
   logic [CS-1:0]   spi_ce_ctrl;
   logic            spi_valid;
   logic            spi_ready_ack;
   logic [15:0]     spi_rdata;
   logic            spi_ready;
   logic            spi_xfer_done;

   lisa_qqspi_arb #(.NUM_REQ(N), .CHIP_SELECTS(CS)) dut (
      .clk(clk), .rst(rst), .prio_fixed(prio_fixed),
      .req_valid(req_valid), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_wstrb(req_wstrb), .req_len(req_len), .req_ce(req_ce),
      .req_ready_ack(req_ready_ack), .req_ready(req_ready), .req_done(req_done),
      .req_rdata(req_rdata), .grant(grant), .spi_addr(spi_addr),
      .spi_wdata(spi_wdata), .spi_wstrb(spi_wstrb), .spi_xfer_len(spi_xfer_len),
      .spi_ce_ctrl(spi_ce_ctrl), .spi_valid(spi_valid), .spi_ready_ack(spi_ready_ack),
      .spi_rdata(spi_rdata), .spi_ready(spi_ready), .spi_xfer_done(spi_xfer_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   checks;
   int   errors;
   bit   mon_en;
   txn_t sb[$];

   // Reference model: 0 idle, 1 issue, 2 transfer, 3 drain.
   int   m_phase;
   int   m_g;
   int   m_rr;
   int   m_beats;
   txn_t m_txn;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input bit fixed, input int rr);
      for (int k = 0; k < N; k++) begin
         int idx;
         idx = fixed ? k : (rr + k) % N;
         if (v[idx]) return idx;
      end
      return 0;
   endfunction

   task automatic monitor_step();
      logic [N-1:0] oh;
      int           nxt;
      bit           found;
      oh = '0;
      oh[m_g] = 1'b1;
      nxt = m_phase;
      case (m_phase)
         0: begin
            chk("idle_grant", grant, 0);
            chk("idle_valid", spi_valid, 0);
            chk("idle_done", req_done, 0);
            if (!rst && req_valid != 0) begin
               m_g = pick(req_valid, prio_fixed, m_rr);
               found = 0;
               for (int j = 0; j < sb.size(); j++) begin
                  if (!found && sb[j].who == 2'(m_g)) begin
                     m_txn = sb[j];
                     sb.delete(j);
                     found = 1;
                  end
               end
               chk("sb_entry_present", found, 1);
               nxt = 1;
            end
         end
         1: begin
            chk("issue_grant", grant, oh);
            chk("issue_valid", spi_valid, 0);
            chk("issue_addr", spi_addr, m_txn.addr);
            chk("issue_wstrb", spi_wstrb, m_txn.wstrb);
            chk("issue_len", spi_xfer_len, m_txn.len);
            chk("issue_ce", spi_ce_ctrl, m_txn.ce);
            m_beats = 0;
            nxt = 2;
         end
         2: begin
            chk("xfer_valid", spi_valid, 1);
            chk("xfer_grant", grant, oh);
            chk("xfer_addr_held", spi_addr, m_txn.addr);
            chk("xfer_wdata", spi_wdata, req_wdata[m_g*16 +: 16]);
            chk("xfer_ack", spi_ready_ack, req_ready_ack[m_g]);
            chk("xfer_ready", req_ready, spi_ready ? oh : '0);
            chk("xfer_rdata", req_rdata, spi_rdata);
            chk("xfer_done", req_done, spi_xfer_done ? oh : '0);
            if (spi_ready) m_beats++;
            if (spi_xfer_done) begin
               chk("beat_count", m_beats, int'(m_txn.len) + 1);
               nxt = 3;
            end
         end
         default: begin
            chk("drain_valid", spi_valid, 0);
            chk("drain_grant", grant, oh);
            chk("drain_ready", req_ready, 0);
            chk("drain_done", req_done, 0);
            if (!spi_ready) begin
               if (!prio_fixed) m_rr = (m_g + 1) % N;
               nxt = 0;
            end
         end
      endcase
      m_phase = nxt;
      if (rst) begin
         m_phase = 0;
         m_rr    = 0;
      end
   endtask

   task automatic run_monitor();
      forever begin
         @(negedge clk);
         if (mon_en) monitor_step();
      end
   endtask

   // Controller: len+1 beats with random gaps, done with the last beat, ready sometimes lingers a cycle.
   task automatic run_ctrl();
      bit act;
      bit linger;
      bit r_prev;
      int beats;
      int wt;
      act = 0; linger = 0; beats = 0; wt = 0;
      forever begin
         @(posedge clk);
         r_prev = rst;
         #2;
         spi_ready     = 1'b0;
         spi_xfer_done = 1'b0;
         if (r_prev) begin
            act = 0;
            linger = 0;
         end else if (linger) begin
            spi_ready = 1'b1;
            linger = 0;
         end else begin
            if (spi_valid && !act) begin
               act   = 1;
               beats = int'(spi_xfer_len) + 1;
               wt    = $urandom_range(0, 2);
            end
            if (act && spi_valid) begin
               if (wt > 0) wt--;
               else begin
                  spi_ready = 1'b1;
                  spi_rdata = 16'($urandom);
                  beats--;
                  wt = $urandom_range(0, 2);
                  if (beats == 0) begin
                     spi_xfer_done = 1'b1;
                     act = 0;
                     linger = bit'($urandom_range(0, 1));
                  end
               end
            end
         end
      end
   endtask

   task automatic run_noise();
      forever begin
         @(posedge clk);
         #1;
         req_wdata     = {N{16'($urandom)}} ^ (N*16)'($urandom);
         req_ready_ack = N'($urandom);
      end
   endtask

   task automatic do_req(input int i, input int dly);
      txn_t t;
      bit   got;
      @(posedge clk); #1;
      repeat (dly) begin @(posedge clk); #1; end
      t.who   = 2'(i);
      t.addr  = 24'($urandom);
      t.wstrb = 2'($urandom_range(0, 3));
      t.len   = 4'($urandom_range(0, 3));
      t.ce    = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      req_addr[i*24 +: 24]  = t.addr;
      req_wstrb[i*2 +: 2]   = t.wstrb;
      req_len[i*4 +: 4]     = t.len;
      req_ce[i*CS +: CS]    = t.ce;
      sb.push_back(t);
      req_valid[i] = 1'b1;
      got = 0;
      for (int c = 0; c < 3000 && !got; c++) begin
         @(negedge clk);
         if (req_done[i]) got = 1;
      end
      chk("req_done_seen", got, 1);
      @(posedge clk); #1;
      req_valid[i] = 1'b0;
   endtask

   initial begin
      txn_t t;
      bit   got;
      checks = 0; errors = 0; mon_en = 0;
      m_phase = 0; m_g = 0; m_rr = 0; m_beats = 0; m_txn = '0;
      rst = 1'b1; prio_fixed = 1'b0; req_valid = '0;
      req_addr = '0; req_wdata = '0; req_wstrb = '0; req_len = '0; req_ce = '0;
      req_ready_ack = '0; spi_rdata = '0; spi_ready = 1'b0; spi_xfer_done = 1'b0;
      fork
         run_monitor();
         run_ctrl();
         run_noise();
      join_none
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      mon_en = 1;

      // Round-robin contention
      fork
         begin repeat (6) do_req(0, $urandom_range(0, 3)); end
         begin repeat (6) do_req(1, $urandom_range(0, 3)); end
      join
      repeat (5) @(posedge clk);
      #1;
      prio_fixed = 1'b1;

      // Fixed priority
      fork
         begin repeat (6) do_req(0, $urandom_range(0, 1)); end
         begin repeat (6) do_req(1, $urandom_range(0, 2)); end
      join
      repeat (5) @(posedge clk);
      #1;
      prio_fixed = 1'b0;

      // Reset mid-transfer: pointer must return to requester 0
      do_req(0, 0);
      @(posedge clk); #1;
      t.who = 2'd1; t.addr = 24'hABCDEF; t.wstrb = 2'b11; t.len = 4'd3; t.ce = 2'b10;
      req_addr[24 +: 24] = t.addr;
      req_wstrb[2 +: 2]  = t.wstrb;
      req_len[4 +: 4]    = t.len;
      req_ce[CS +: CS]   = t.ce;
      sb.push_back(t);
      req_valid[1] = 1'b1;
      got = 0;
      for (int c = 0; c < 100 && !got; c++) begin
         @(negedge clk);
         if (grant[1] && spi_valid) got = 1;
      end
      chk("reset_setup", got, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      fork
         do_req(0, 0);
         do_req(1, 0);
      join

      repeat (10) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
